sobel_mac_ci: RTL and testbench
===============================

# sobel_mac_ci

Pipelined, parametrised Sobel multiply-accumulate custom instruction for the soft CPU's custom-instruction port. It is the successor to the single-value shift-by-1/2 multiplier. Each call multiplies up to four packed 8-bit pixels by per-lane Sobel coefficients in {-2,-1,0,1,2} and accumulates the sum into one of two gradient accumulators (X/Y). A magnitude op returns the clamped |Gx|+|Gy| in a single call. The block is fully pipelined with a fixed 2-cycle latency.

## Interface
- customId, 8'h18, custom-instruction number this block responds to
- NR_LANES, 4, pixels processed per call (1..4); lanes >= NR_LANES contribute 0
- ACC_WIDTH, 16, signed accumulator width (12..31)

- clock  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start  in  1  one-cycle call strobe from CPU
- ciN  in  8  custom-instruction number; call accepted only when start & ciN==customId
- valueA  in  32  packed pixels, lane i = valueA[8i+7:8i], unsigned
- valueB  in  32  [31:30] op, [29] acc select (0=X, 1=Y), [3i+2:3i] lane-i coefficient (3-bit signed)
- done  out  1  one-cycle completion pulse
- result  out  32  valid only while done=1, else 32'h0 (the result bus is OR-combined)

## Operation
- ops: 0 MAC, 1 CLEAR, 2 READ, 3 MAG
- coefficient decode: 000=0, 001=+1, 010=+2, 111=-1, 110=-2; codes 011, 100, 101 are illegal and decode to 0; products implemented as shift/negate, no multiplier
- MAC: acc[sel] += sum over lanes of pixel_i*coef_i; lane sum is 12-bit signed (range ±2040), sign-extended to ACC_WIDTH; acc wraps two's complement; result = new acc[sel] sign-extended to 32
- CLEAR: accX=accY=0; result 0
- READ: result = acc[sel] sign-extended; accs unchanged
- MAG: m = |accX|+|accY| computed at ACC_WIDTH+1 bits unsigned; result = min(m,255) zero-extended; then accX=accY=0
- non-matching ciN or start=0: no state change, no done
- reset: accX=accY=0, all pipeline valids 0, done=0, result=0

## Timing
- stage 1 (edge after start cycle T): decode, lane sum, op/sel registered with valid
- stage 2 (edge ending T+1): accumulator update/read/clear; done=1 and result driven in cycle T+2
- throughput 1 call/cycle; calls complete in issue order; all accumulator reads/writes occur only in stage 2, so back-to-back dependent ops see each prior update (no hazard, no stall)
- reset asserted during any cycle of an in-flight call kills it: no done, accs cleared
- done is never high for two calls in the same cycle; result=0 whenever done=0

## Structure
- sobel_pkg: op enum (OP_MAC, OP_CLEAR, OP_READ, OP_MAG), PIX_W=8, COEF_W=3, LANE_SUM_W=12, MAG_MAX=255, coef decode function
- sub-module sobel_lane_sum: combinational NR_LANES-wide shift/negate product and adder tree, instantiated in stage 1

## Test plan
- reset, MAC X, valueA=0x10203040, valueB=0x00000E11 -> done at T+2, result 0x00000090 (64+96+0-16=144)
- then MAC Y, valueA=0x000000FF, valueB=0x20000006 -> result 0xFFFFFE02; MAG -> 0x000000FF; READ X -> 0x0
- three consecutive MAC X calls, valueA=1, valueB=0x1 -> done on three consecutive cycles, results 1,2,3
- start with ciN=0x17 -> done stays 0, result 0; subsequent READ X unchanged
- illegal coef 011 on lane 0 -> contributes 0; NR_LANES=2 instance, valueA=0xFFFF0000, all coefs +1 -> result 0; 17 MACs of +2040 (ACC_WIDTH=16) -> wraps to 0xFFFF8778 (-30856)
- MAC issued, reset pulsed in cycle T+1 -> no done at T+2, READ X afterwards returns 0

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel MAC custom instruction.
// Coefficient decode lives here so lane logic and any future users agree.
package sobel_pkg;

  typedef enum logic [1:0] {
    OP_MAC   = 2'd0,
    OP_CLEAR = 2'd1,
    OP_READ  = 2'd2,
    OP_MAG   = 2'd3
  } op_e;

  localparam int PIX_W      = 8;
  localparam int COEF_W     = 3;
  localparam int LANE_SUM_W = 12;
  localparam int MAG_MAX    = 255;
  localparam int MAX_LANES  = 4;

  typedef struct packed {
    logic zero;
    logic neg;
    logic dbl;
  } coef_t;

  typedef struct packed {
    logic                  valid;
    op_e                   op;
    logic                  sel;
    logic [LANE_SUM_W-1:0] sum;
  } s1_t;

  function automatic coef_t coef_decode(
    input logic [COEF_W-1:0] c
  );
    coef_t d;
    d = '{zero: 1'b1, neg: 1'b0, dbl: 1'b0};
    case (c)
      3'b001: d = '{zero: 1'b0, neg: 1'b0, dbl: 1'b0};
      3'b010: d = '{zero: 1'b0, neg: 1'b0, dbl: 1'b1};
      3'b111: d = '{zero: 1'b0, neg: 1'b1, dbl: 1'b0};
      3'b110: d = '{zero: 1'b0, neg: 1'b1, dbl: 1'b1};
      default: d = '{zero: 1'b1, neg: 1'b0, dbl: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sobel_lane_sum.sv
// Combinational per-lane shift/negate products and their sum.
// Lanes at or above NR_LANES are forced to contribute zero.
module sobel_lane_sum
  import sobel_pkg::*;
#(
  parameter int NR_LANES = 4
) (
  input  logic [31:0]                  pixels,
  input  logic [11:0]                  coefs,
  output logic signed [LANE_SUM_W-1:0] sum
);

  coef_t                         d;
  logic signed [LANE_SUM_W-1:0] p;

  // Shift for |coef|=2, negate for negative coef, then accumulate lanes.
  always_comb begin
    sum = '0;
    d   = '0;
    p   = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      d = coef_decode(coefs[COEF_W*i +: COEF_W]);
      p = '0;
      p[PIX_W-1:0] = pixels[PIX_W*i +: PIX_W];
      if (d.dbl) p = p <<< 1;
      if (d.neg) p = -p;
      if (d.zero || (i >= NR_LANES)) p = '0;
      sum = sum + p;
    end
  end

endmodule

// File: rtl/sobel_mac_ci.sv
// Two-stage Sobel multiply-accumulate custom instruction.
// Stage 1 forms the lane sum; stage 2 owns the X/Y accumulators.
module sobel_mac_ci
  import sobel_pkg::*;
#(
  parameter logic [7:0] customId  = 8'h18,
  parameter int         NR_LANES  = 4,
  parameter int         ACC_WIDTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  logic signed [LANE_SUM_W-1:0] lane_sum;
  s1_t                          s1_d;
  s1_t                          s1_q;
  logic signed [ACC_WIDTH-1:0]  acc_x;
  logic signed [ACC_WIDTH-1:0]  acc_y;
  logic signed [LANE_SUM_W-1:0] s1_sum;
  logic signed [ACC_WIDTH-1:0]  acc_cur;
  logic signed [ACC_WIDTH-1:0]  acc_mac;
  logic [ACC_WIDTH-1:0]         abs_x;
  logic [ACC_WIDTH-1:0]         abs_y;
  logic [ACC_WIDTH:0]           mag;
  logic [31:0]                  res_d;
  logic                         unused_b;

  assign unused_b = ^valueB[28:12];

  sobel_lane_sum #(
    .NR_LANES(NR_LANES)
  ) u_lane_sum (
    .pixels(valueA),
    .coefs (valueB[11:0]),
    .sum   (lane_sum)
  );

  // Bundle the accepted call for stage 1.
  always_comb begin
    s1_d       = '0;
    s1_d.valid = start && (ciN == customId);
    s1_d.op    = op_e'(valueB[31:30]);
    s1_d.sel   = valueB[29];
    s1_d.sum   = lane_sum;
  end

  // Stage 1 register: decoded call and lane sum.
  always_ff @(posedge clock) begin
    if (reset) s1_q <= '0;
    else       s1_q <= s1_d;
  end

  // Stage 2 datapath: accumulate, read and clamped magnitude.
  always_comb begin
    s1_sum  = s1_q.sum;
    acc_cur = s1_q.sel ? acc_y : acc_x;
    acc_mac = acc_cur + ACC_WIDTH'(s1_sum);
    abs_x   = acc_x[ACC_WIDTH-1] ? -acc_x : acc_x;
    abs_y   = acc_y[ACC_WIDTH-1] ? -acc_y : acc_y;
    mag     = {1'b0, abs_x} + {1'b0, abs_y};
    res_d   = '0;
    case (s1_q.op)
      OP_MAC:   res_d = 32'(acc_mac);
      OP_READ:  res_d = 32'(acc_cur);
      OP_MAG: begin
        if (mag > (ACC_WIDTH+1)'(MAG_MAX)) res_d = 32'(MAG_MAX);
        else                               res_d = 32'(mag);
      end
      default:  res_d = '0;
    endcase
  end

  // Stage 2 register: accumulators, done pulse and gated result.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_x  <= '0;
      acc_y  <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done   <= s1_q.valid;
      result <= s1_q.valid ? res_d : '0;
      if (s1_q.valid) begin
        case (s1_q.op)
          OP_MAC: begin
            if (s1_q.sel) acc_y <= acc_mac;
            else          acc_x <= acc_mac;
          end
          OP_CLEAR, OP_MAG: begin
            acc_x <= '0;
            acc_y <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sobel_mac_ci.sv
// Directed bench for sobel_mac_ci: latency, ops, wrap, lanes, reset.
// Expected values are hand-computed constants.
module tb_sobel_mac_ci;

  logic        clock  = 1'b0;
  logic        reset  = 1'b1;
  logic        start  = 1'b0;
  logic        start2 = 1'b0;
  logic [7:0]  ciN    = 8'h18;
  logic [31:0] valueA = '0;
  logic [31:0] valueB = '0;
  logic        done;
  logic        done2;
  logic [31:0] result;
  logic [31:0] result2;
  int          checks = 0;
  int          errors = 0;

  localparam logic [31:0] B_CLR  = 32'h4000_0000;
  localparam logic [31:0] B_READ = 32'h8000_0000;
  localparam logic [31:0] B_MAG  = 32'hC000_0000;
  localparam logic [31:0] SEL_Y  = 32'h2000_0000;

  sobel_mac_ci dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .ciN   (ciN),
    .valueA(valueA),
    .valueB(valueB),
    .done  (done),
    .result(result)
  );

  sobel_mac_ci #(.NR_LANES(2)) dut2 (
    .clock (clock),
    .reset (reset),
    .start (start2),
    .ciN   (ciN),
    .valueA(valueA),
    .valueB(valueB),
    .done  (done2),
    .result(result2)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] ci);
    @(negedge clock);
    start  = 1'b1;
    ciN    = ci;
    valueA = a;
    valueB = b;
  endtask

  task automatic idle();
    @(negedge clock);
    start  = 1'b0;
    start2 = 1'b0;
    ciN    = 8'h18;
    valueA = '0;
    valueB = '0;
  endtask

  task automatic run_call(input logic [31:0] a, input logic [31:0] b);
    drive(a, b, 8'h18);
    idle();
    idle();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: done=%b result=%h, expected 0/0",
               done, result);
    end
    checks++;
    if (done2 !== 1'b0 || result2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_state2: done=%b result=%h, expected 0/0",
               done2, result2);
    end
    reset = 1'b0;
    drive(32'h0, B_READ, 8'h18);
    idle();
    idle();
    checks++;
    if (done !== 1'b1 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_read: done=%b result=%h, expected 1/0",
               done, result);
    end
    idle();
  endtask

  task automatic test_mac_x();
    drive(32'h1020_3040, 32'h0000_0E11, 8'h18);
    idle();
    checks++;
    if (done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL mac_x_t1: done=%b result=%h, expected 0/0",
               done, result);
    end
    idle();
    checks++;
    if (done !== 1'b1 || result !== 32'h90) begin
      errors++;
      $display("FAIL mac_x_t2: done=%b result=%h, expected 1/00000090",
               done, result);
    end
    idle();
    checks++;
    if (done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL mac_x_t3: done=%b result=%h, expected 0/0",
               done, result);
    end
  endtask

  task automatic test_mac_y_mag();
    drive(32'h0000_00FF, SEL_Y | 32'h6, 8'h18);
    drive(32'h0, B_MAG, 8'h18);
    drive(32'h0, B_READ, 8'h18);
    checks++;
    if (done !== 1'b1 || result !== 32'hFFFF_FE02) begin
      errors++;
      $display("FAIL mac_y: done=%b result=%h, expected 1/fffffe02",
               done, result);
    end
    drive(32'h0, B_READ | SEL_Y, 8'h18);
    checks++;
    if (done !== 1'b1 || result !== 32'hFF) begin
      errors++;
      $display("FAIL mag_clamp: done=%b result=%h, expected 1/000000ff",
               done, result);
    end
    idle();
    checks++;
    if (done !== 1'b1 || result !== 32'h0) begin
      errors++;
      $display("FAIL read_x_after_mag: done=%b result=%h, expected 1/0",
               done, result);
    end
    idle();
    checks++;
    if (done !== 1'b1 || result !== 32'h0) begin
      errors++;
      $display("FAIL read_y_after_mag: done=%b result=%h, expected 1/0",
               done, result);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    run_call(32'h0, B_CLR);
    drive(32'h1, 32'h1, 8'h18);
    drive(32'h1, 32'h1, 8'h18);
    drive(32'h1, 32'h1, 8'h18);
    checks++;
    if (done !== 1'b1 || result !== 32'h1) begin
      errors++;
      $display("FAIL b2b_1: done=%b result=%h, expected 1/1", done, result);
    end
    idle();
    checks++;
    if (done !== 1'b1 || result !== 32'h2) begin
      errors++;
      $display("FAIL b2b_2: done=%b result=%h, expected 1/2", done, result);
    end
    idle();
    checks++;
    if (done !== 1'b1 || result !== 32'h3) begin
      errors++;
      $display("FAIL b2b_3: done=%b result=%h, expected 1/3", done, result);
    end
    idle();
    checks++;
    if (done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL b2b_end: done=%b result=%h, expected 0/0",
               done, result);
    end
  endtask

  task automatic test_wrong_id();
    drive(32'h1, 32'h1, 8'h17);
    for (int k = 0; k < 3; k++) begin
      idle();
      checks++;
      if (done !== 1'b0 || result !== 32'h0) begin
        errors++;
        $display("FAIL wrong_id_c%0d: done=%b result=%h, expected 0/0",
                 k, done, result);
      end
    end
    drive(32'h0, B_READ, 8'h18);
    idle();
    idle();
    checks++;
    if (done !== 1'b1 || result !== 32'h3) begin
      errors++;
      $display("FAIL wrong_id_read: done=%b result=%h, expected 1/3",
               done, result);
    end
    idle();
  endtask

  task automatic test_illegal_coef();
    run_call(32'h0, B_CLR);
    drive(32'h0000_00FF, 32'h3, 8'h18);
    drive(32'h00FF_FFFF, 32'h163, 8'h18);
    idle();
    checks++;
    if (done !== 1'b1 || result !== 32'h0) begin
      errors++;
      $display("FAIL illegal_011: done=%b result=%h, expected 1/0",
               done, result);
    end
    idle();
    checks++;
    if (done !== 1'b1 || result !== 32'h0) begin
      errors++;
      $display("FAIL illegal_100_101: done=%b result=%h, expected 1/0",
               done, result);
    end
    idle();
  endtask

  task automatic test_nr_lanes();
    @(negedge clock);
    start2 = 1'b1;
    valueA = 32'hFFFF_0000;
    valueB = 32'h249;
    @(negedge clock);
    valueA = 32'h0000_FFFF;
    valueB = 32'h249;
    @(negedge clock);
    start2 = 1'b0;
    checks++;
    if (done2 !== 1'b1 || result2 !== 32'h0) begin
      errors++;
      $display("FAIL lanes2_upper: done=%b result=%h, expected 1/0",
               done2, result2);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL lanes2_main_idle: done=%b, expected 0", done);
    end
    idle();
    checks++;
    if (done2 !== 1'b1 || result2 !== 32'h1FE) begin
      errors++;
      $display("FAIL lanes2_lower: done=%b result=%h, expected 1/000001fe",
               done2, result2);
    end
    idle();
  endtask

  task automatic test_wrap();
    int          v;
    logic [31:0] exp;
    run_call(32'h0, B_CLR);
    for (int k = 0; k < 19; k++) begin
      if (k < 17) drive(32'hFFFF_FFFF, 32'h492, 8'h18);
      else        idle();
      if (k >= 2) begin
        v = (2040 * (k - 1)) % 65536;
        if (v >= 32768) v = v - 65536;
        exp = 32'(v);
        checks++;
        if (done !== 1'b1 || result !== exp) begin
          errors++;
          $display("FAIL wrap_%0d: done=%b result=%h, expected 1/%h",
                   k - 2, done, result, exp);
        end
      end
    end
    idle();
    checks++;
    if (result !== 32'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: done=%b result=%h, expected 0/0",
               done, result);
    end
  endtask

  task automatic test_reset_kill();
    run_call(32'h1, 32'h1);
    drive(32'h1, 32'h1, 8'h18);
    @(negedge clock);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL kill_t2: done=%b result=%h, expected 0/0",
               done, result);
    end
    idle();
    checks++;
    if (done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL kill_t3: done=%b result=%h, expected 0/0",
               done, result);
    end
    drive(32'h0, B_READ, 8'h18);
    idle();
    idle();
    checks++;
    if (done !== 1'b1 || result !== 32'h0) begin
      errors++;
      $display("FAIL kill_read_x: done=%b result=%h, expected 1/0",
               done, result);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_mac_x();
    test_mac_y_mag();
    test_back_to_back();
    test_wrong_id();
    test_illegal_coef();
    test_nr_lanes();
    test_wrap();
    test_reset_kill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
